// File: rtl/alu_pkg.sv
// Shared definitions for the ALU serial front end: opcodes, error-flag positions,
// packet field sizes and the CRC4 used to protect each transaction.
package alu_pkg;

  typedef enum logic [2:0] {
    OpAnd = 3'b000,
    OpOr  = 3'b001,
    OpAdd = 3'b100,
    OpSub = 3'b101
  } operation_t;

  localparam int unsigned ErrData = 2;
  localparam int unsigned ErrCrc  = 1;
  localparam int unsigned ErrOp   = 0;

  localparam int unsigned PktBits      = 11;
  localparam int unsigned PktShiftBits = PktBits - 1;  // bits following the start bit
  localparam int unsigned PayloadBits  = 8;
  localparam int unsigned DataBytes    = 8;
  localparam int unsigned OpBits       = 3;
  localparam int unsigned CrcBits      = 4;
  localparam int unsigned CrcMsgBits   = 68;

  // CRC4, poly x^4+x+1, init 0, message consumed MSB first.
  function automatic logic [CrcBits-1:0] crc4_68(input logic [CrcMsgBits-1:0] msg);
    logic [CrcBits-1:0] c;
    logic               fb;
    c = '0;
    for (int i = CrcMsgBits - 1; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  function automatic logic op_legal(input logic [OpBits-1:0] op);
    logic legal;
    case (op)
      OpAnd, OpOr, OpAdd, OpSub: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_rx_framer.sv
// Bit-level framer: finds a start bit, shifts in the remaining ten bits and
// presents the packet fields for one cycle while the stop bit is evaluated.
module alu_rx_framer
  import alu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sin,
  output logic                   pkt_valid,
  output logic                   pkt_is_cmd,
  output logic [PayloadBits-1:0] pkt_payload,
  output logic                   pkt_frame_err,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  localparam logic [3:0] LastIdx = 4'(PktShiftBits - 1);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [PktShiftBits-1:0] shreg_q, shreg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // CHECK also watches for a start bit so packets can run back to back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    unique case (state_q)
      StIdle, StCheck: begin
        if (!sin) begin
          state_d = StShift;
          cnt_d   = LastIdx;
          shreg_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        shreg_d = {shreg_q[PktShiftBits-2:0], sin};
        if (cnt_q == 4'd0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pkt_valid     = (state_q == StCheck) & shreg_q[0];
    pkt_frame_err = (state_q == StCheck) & ~shreg_q[0];
    pkt_is_cmd    = shreg_q[PktShiftBits-1];
    pkt_payload   = shreg_q[PayloadBits:1];
    busy          = (state_q != StIdle);
  end

endmodule

// File: rtl/alu_serial_rx.sv
// Serial front end of the ALU: assembles eight data bytes and a command packet
// into operands and opcode, checks the transaction and reports one result.
module alu_serial_rx
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        rx_busy
);

  typedef enum logic {StCollect, StReport} asm_state_e;

  localparam logic [3:0] FullCnt = 4'(DataBytes);

  logic                   pkt_valid;
  logic                   pkt_is_cmd;
  logic [PayloadBits-1:0] pkt_payload;
  logic                   pkt_frame_err;
  logic                   framer_busy;

  alu_rx_framer u_framer (
    .clk           (clk),
    .rst           (rst),
    .sin           (sin),
    .pkt_valid     (pkt_valid),
    .pkt_is_cmd    (pkt_is_cmd),
    .pkt_payload   (pkt_payload),
    .pkt_frame_err (pkt_frame_err),
    .busy          (framer_busy)
  );

  asm_state_e  asm_q, asm_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic        corrupt_q, corrupt_d;
  logic [63:0] data_q, data_d;  // {B, A} once all eight bytes are in
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_a_q, out_a_d;
  logic [31:0] out_b_q, out_b_d;
  logic [2:0]  out_op_q, out_op_d;
  logic [2:0]  out_err_q, out_err_d;

  logic               data_pkt;
  logic               cmd_pkt;
  logic [OpBits-1:0]  cmd_op;
  logic [CrcBits-1:0] cmd_crc;
  logic [CrcBits-1:0] calc_crc;
  logic [2:0]         err_vec;

  assign data_pkt = pkt_valid & ~pkt_is_cmd;
  assign cmd_pkt  = pkt_valid & pkt_is_cmd;
  assign cmd_op   = pkt_payload[6:4];
  assign cmd_crc  = pkt_payload[3:0];
  assign calc_crc = crc4_68({data_q, 1'b1, cmd_op});

  // First failing check wins, so at most one flag is ever set.
  always_comb begin
    err_vec = '0;
    if (corrupt_q || (byte_cnt_q != FullCnt)) begin
      err_vec[ErrData] = 1'b1;
    end else if (cmd_crc != calc_crc) begin
      err_vec[ErrCrc] = 1'b1;
    end else if (!op_legal(cmd_op)) begin
      err_vec[ErrOp] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= StCollect;
      byte_cnt_q  <= '0;
      corrupt_q   <= 1'b0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_op_q    <= '0;
      out_err_q   <= '0;
    end else begin
      asm_q       <= asm_d;
      byte_cnt_q  <= byte_cnt_d;
      corrupt_q   <= corrupt_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_op_q    <= out_op_d;
      out_err_q   <= out_err_d;
    end
  end

  always_comb begin
    asm_d = asm_q;
    unique case (asm_q)
      StCollect: if (cmd_pkt) asm_d = StReport;
      StReport:  asm_d = StCollect;
      default:   asm_d = StCollect;
    endcase
  end

  // Result is registered on the edge that consumes the command packet.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    corrupt_d   = corrupt_q;
    data_d      = data_q;
    out_valid_d = 1'b0;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_op_d    = out_op_q;
    out_err_d   = out_err_q;
    if (asm_q == StCollect) begin
      if (pkt_frame_err) begin
        corrupt_d = 1'b1;
      end else if (data_pkt) begin
        if (byte_cnt_q < FullCnt) begin
          data_d     = {data_q[63-PayloadBits:0], pkt_payload};
          byte_cnt_d = byte_cnt_q + 4'd1;
        end else begin
          corrupt_d = 1'b1;
        end
      end else if (cmd_pkt) begin
        out_valid_d = 1'b1;
        out_err_d   = err_vec;
        out_b_d     = (err_vec == 3'b000) ? data_q[63:32] : 32'h0;
        out_a_d     = (err_vec == 3'b000) ? data_q[31:0] : 32'h0;
        out_op_d    = (err_vec == 3'b000) ? cmd_op : 3'b000;
        byte_cnt_d  = '0;
        corrupt_d   = 1'b0;
        data_d      = '0;
      end
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    out_a     = out_a_q;
    out_b     = out_b_q;
    out_op    = out_op_q;
    out_err   = out_err_q;
    rx_busy   = framer_busy | (asm_q == StReport) | (byte_cnt_q != 4'd0);
  end

endmodule

// File: doc/alu_serial_rx.md
# alu_serial_rx

Serial front end of the ALU datapath: deserialises the 11-bit packet stream on `sin` into two 32-bit operands and an opcode. It checks framing, packet count, CRC and opcode legality, then presents one registered result per transaction. It sits directly upstream of the ALU core and consumes exactly the packet format the team's ALU bench drives.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  the single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `sin`  in  1  serial input, idles high, one bit sampled per rising edge.
- `out_valid`  out  1  one-cycle pulse: transaction complete (ok or error).
- `out_a`  out  32  operand A, valid with `out_valid`, 0 on error.
- `out_b`  out  32  operand B, valid with `out_valid`, 0 on error.
- `out_op`  out  3  opcode, valid with `out_valid`, 0 on error.
- `out_err`  out  3  error flags {ERR_DATA, ERR_CRC, ERR_OP}, at most one bit set, valid with `out_valid`.
- `rx_busy`  out  1  high while a packet is being shifted or a transaction is open.

## Operation
- Packet is 11 bits, first on wire = bit 10:
  - bit 10: start, 0.
  - bit 9: type, 0 = data, 1 = command.
  - bits 8:1: payload.
  - bit 0: stop, 1.
- Data payload is one byte, MSB first.
- Command payload: bit 8 is 0, bits 7:5 are op, bits 4:1 are crc[3:0].
- Transaction is exactly 8 data packets, then 1 command packet.
  - Bytes 0..3 → B[31:24], B[23:16], B[15:8], B[7:0].
  - Bytes 4..7 → A[31:24], A[23:16], A[15:8], A[7:0].
- Framer states:
  - IDLE: `sin`=0 → SHIFT, bit counter = 9.
  - SHIFT: sample 10 further bits.
  - CHECK: stop bit evaluated, then back to IDLE.
- Stop bit 0 (framing error): packet discarded and transaction marked corrupt.
- Assembler states:
  - COLLECT: counts data bytes 0..8.
    - A 9th data packet marks the transaction corrupt.
    - Further data packets are ignored (counter saturates).
  - REPORT: entered on a command packet; one cycle.
- Checks in REPORT, in priority order; first hit wins:
  - ERR_DATA: transaction corrupt or byte count ≠ 8.
  - ERR_CRC: received crc ≠ CRC4 over the 68-bit message {B, A, 1'b1, op}, MSB first.
    - CRC4: poly x^4+x+1, init 0.
    - Serial update per message bit: fb = c[3]^bit; c = {c[2:0],0} ^ (fb ? 4'b0011 : 0).
  - ERR_OP: op not in {AND=000, OR=001, ADD=100, SUB=101}.
- After REPORT: byte count and corrupt flag cleared; return to COLLECT.
- No timeout: a partial transaction waits indefinitely.

## Timing
- Reset: all outputs 0; framer IDLE; counters and corrupt flag cleared.
- Reset mid-packet or mid-transaction discards everything.
  - `rst` has priority over a simultaneous command completion, so no `out_valid` results.
- Start bit sampled at edge N → stop bit sampled at edge N+10.
- For a command packet, `out_valid` and the outputs are registered high for the single cycle after edge N+11.
  - Outputs hold their values afterwards; only `out_valid` drops.
- Back-to-back packets: a start bit is accepted on the edge immediately after a stop-bit sample.
  - Minimum packet period is 11 cycles.
- `rx_busy` is high from the cycle after the start-bit edge until the cycle after REPORT or a framing discard.
  - It also stays high while 1..8 data bytes are held.

## Structure
- `alu_pkg` (shared):
  - `operation_t` enum (AND/OR/ADD/SUB encodings above).
  - Error-flag bit positions: ERR_DATA=2, ERR_CRC=1, ERR_OP=0.
  - Packet field constants.
  - `crc4_68` function, reused by the ALU output stage and the scoreboard.
- Sub-module `alu_rx_framer`: bit-level IDLE/SHIFT/CHECK machine.
  - Outputs `pkt_valid`, `pkt_is_cmd`, `pkt_payload[7:0]`, `pkt_frame_err`.
- `alu_serial_rx`: framer instance plus assembler, CRC and checks.

## Test plan
- A=0, B=0, op=000, crc=4'b1011 → `out_valid` 1 cycle; `out_a`=0, `out_b`=0, `out_op`=000, `out_err`=000; 11 cycles after command start edge.
- A=0, B=0, op=100, crc=4'b0111 → ok, `out_op`=100.
- Same data, op=000, crc=4'b0000 → `out_err`=010, `out_a`/`out_b`/`out_op`=0.
- A=0, B=0, op=010, crc=4'b1101 (CRC correct) → `out_err`=001.
- 7 data packets then command (any crc) → `out_err`=100.
  - Repeat with 9 data packets → 100.
  - Repeat with one data stop bit = 0 → 100.
- `rst` pulsed at 5th data byte, then full valid transaction (op=100, crc=0111) → no output before it; exactly one ok result for it.
